// File: rtl/store_buffer_if.sv
// Bundle of the datapath memory-stage port, the backing-memory write drain,
// the backing-memory read port and the occupancy status of the store buffer.
interface store_buffer_if #(
   parameter int N     = 64,
   parameter int DEPTH = 4
);
   logic [N-1:0]               DM_addr;
   logic [N-1:0]               DM_writeData;
   logic                       DM_writeEnable;
   logic                       DM_readEnable;
   logic [N-1:0]               DM_readData;
   logic                       stall;
   // Drain handshake: the head entry moves to memory on an edge where
   // mem_wr_req and mem_wr_ack are both 1; address/data hold until then.
   logic                       mem_wr_req;
   logic [N-1:0]               mem_wr_addr;
   logic [N-1:0]               mem_wr_data;
   logic                       mem_wr_ack;
   logic [N-1:0]               mem_rd_addr;
   logic [N-1:0]               mem_rd_data;
   logic [$clog2(DEPTH):0]     count;
   logic                       empty;

   modport slave (
      input  DM_addr, DM_writeData, DM_writeEnable, DM_readEnable,
      input  mem_wr_ack, mem_rd_data,
      output DM_readData, stall, mem_wr_req, mem_wr_addr, mem_wr_data,
      output mem_rd_addr, count, empty
   );

   modport master (
      output DM_addr, DM_writeData, DM_writeEnable, DM_readEnable,
      output mem_wr_ack, mem_rd_data,
      input  DM_readData, stall, mem_wr_req, mem_wr_addr, mem_wr_data,
      input  mem_rd_addr, count, empty
   );
endinterface

// File: rtl/store_buffer.sv
// Write-back store buffer: absorbs stores into a circular FIFO, drains them in
// order to the backing memory and forwards the youngest matching entry to loads.
module store_buffer #(
   parameter int N     = 64,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   store_buffer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [N-1:0]  addr_q [DEPTH];
   logic [N-1:0]  data_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic          full;
   logic          push;
   logic          pop;
   logic [N-1:0]  fwd_data;
   logic [PW-1:0] idx;

   assign full = (count_q == CW'(DEPTH));
   // A store arriving while full is refused even if the head pops this edge.
   assign push = bus.DM_writeEnable & ~full;
   assign pop  = (count_q != '0) & bus.mem_wr_ack;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage carries no reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= bus.DM_addr;
         data_q[tail_q] <= bus.DM_writeData;
      end
   end

   // Walk from oldest to youngest so the last match found wins.
   always_comb begin
      fwd_data = bus.mem_rd_data;
      idx      = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if ((CW'(i) < count_q) && (addr_q[idx] == bus.DM_addr))
            fwd_data = data_q[idx];
      end
   end

   assign bus.DM_readData = bus.DM_readEnable ? fwd_data : bus.mem_rd_data;
   assign bus.stall       = bus.DM_writeEnable & full;
   assign bus.mem_wr_req  = (count_q != '0);
   assign bus.mem_wr_addr = addr_q[head_q];
   assign bus.mem_wr_data = data_q[head_q];
   assign bus.mem_rd_addr = bus.DM_addr;
   assign bus.count       = count_q;
   assign bus.empty       = (count_q == '0);
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, ordered drain, full/stall, forwarding,
// simultaneous push/pop and asynchronous reset mid-drain.
module tb_store_buffer;
  localparam int N     = 64;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  store_buffer_if #(.N(N), .DEPTH(DEPTH)) bus ();

  store_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge, outputs settle before the next
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [N-1:0] a, input logic [N-1:0] d);
    bus.DM_writeEnable = 1'b1;
    bus.DM_addr        = a;
    bus.DM_writeData   = d;
    tick();
    bus.DM_writeEnable = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [N-1:0] a, input logic [N-1:0] d);
    check({tag, "_req"},  {63'd0, bus.mem_wr_req}, 64'd1);
    check({tag, "_addr"}, bus.mem_wr_addr, a);
    check({tag, "_data"}, bus.mem_wr_data, d);
    bus.mem_wr_ack = 1'b1;
    tick();
    bus.mem_wr_ack = 1'b0;
  endtask

  task automatic load_expect(input string tag, input logic [N-1:0] a,
                             input logic [N-1:0] mem, input logic [N-1:0] exp);
    bus.DM_readEnable = 1'b1;
    bus.DM_addr       = a;
    bus.mem_rd_data   = mem;
    #1;
    check({tag, "_rdaddr"}, bus.mem_rd_addr, a);
    check(tag, bus.DM_readData, exp);
    bus.DM_readEnable = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset              = 1'b0;
    bus.DM_addr        = 64'h8;
    bus.DM_writeData   = 64'h9;
    bus.DM_writeEnable = 1'b1;
    bus.DM_readEnable  = 1'b0;
    bus.mem_wr_ack     = 1'b0;
    bus.mem_rd_data    = 64'h0;

    // 1. reset behaviour
    #2;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_empty", {63'd0, bus.empty}, 64'd1);
    check("rst_req",   {63'd0, bus.mem_wr_req}, 64'd0);
    check("rst_stall", {63'd0, bus.stall}, 64'd0);
    tick(); tick();
    check("rst_hold_count", 64'(bus.count), 64'd0);
    reset = 1'b1;
    tick();
    bus.DM_writeEnable = 1'b0;
    check("rel_count", 64'(bus.count), 64'd1);
    pop_expect("rel_pop", 64'h8, 64'h9);
    check("rel_empty", {63'd0, bus.empty}, 64'd1);

    // 2. in-order drain
    store(64'h10, 64'h11);
    store(64'h18, 64'h22);
    store(64'h20, 64'h33);
    check("ord_count", 64'(bus.count), 64'd3);
    pop_expect("ord0", 64'h10, 64'h11);
    pop_expect("ord1", 64'h18, 64'h22);
    pop_expect("ord2", 64'h20, 64'h33);
    check("ord_empty", {63'd0, bus.empty}, 64'd1);

    // 3. full and stall, tail wrap
    for (int i = 0; i < 4; i++) store(64'h60 + 64'(8 * i), 64'hA0 + 64'(i));
    check("full_count", 64'(bus.count), 64'd4);
    bus.DM_writeEnable = 1'b1;
    bus.DM_addr        = 64'h40;
    bus.DM_writeData   = 64'h55;
    #1;
    check("full_stall", {63'd0, bus.stall}, 64'd1);
    tick();
    check("full_hold", 64'(bus.count), 64'd4);
    bus.mem_wr_ack = 1'b1;
    #1;
    check("full_stall_ack", {63'd0, bus.stall}, 64'd1);
    tick();
    bus.mem_wr_ack = 1'b0;
    check("full_refused", 64'(bus.count), 64'd3);
    check("full_unstall", {63'd0, bus.stall}, 64'd0);
    tick();
    bus.DM_writeEnable = 1'b0;
    check("full_again", 64'(bus.count), 64'd4);
    pop_expect("wrap0", 64'h68, 64'hA1);
    pop_expect("wrap1", 64'h70, 64'hA2);
    pop_expect("wrap2", 64'h78, 64'hA3);
    pop_expect("wrap3", 64'h40, 64'h55);
    check("wrap_empty", {63'd0, bus.empty}, 64'd1);

    // 4. forwarding
    store(64'h100, 64'hAAAA);
    store(64'h100, 64'hBBBB);
    load_expect("fwd_young", 64'h100, 64'h1234, 64'hBBBB);
    load_expect("fwd_miss",  64'h108, 64'h1234, 64'h1234);
    pop_expect("fwd_pop0", 64'h100, 64'hAAAA);
    load_expect("fwd_head", 64'h100, 64'h1234, 64'hBBBB);
    pop_expect("fwd_pop1", 64'h100, 64'hBBBB);
    load_expect("fwd_gone", 64'h100, 64'h1234, 64'h1234);

    // 5. simultaneous push and pop
    store(64'h300, 64'h1);
    store(64'h308, 64'h2);
    check("pp_count0", 64'(bus.count), 64'd2);
    bus.DM_writeEnable = 1'b1;
    bus.DM_writeData   = 64'h3;
    bus.mem_wr_ack     = 1'b1;
    load_expect("pp_nofwd", 64'h310, 64'h1234, 64'h1234);
    check("pp_nostall", {63'd0, bus.stall}, 64'd0);
    tick();
    bus.DM_writeEnable = 1'b0;
    bus.mem_wr_ack     = 1'b0;
    check("pp_count1", 64'(bus.count), 64'd2);
    load_expect("pp_fwd", 64'h310, 64'h1234, 64'h3);
    pop_expect("pp_pop0", 64'h308, 64'h2);
    pop_expect("pp_pop1", 64'h310, 64'h3);
    check("pp_empty", {63'd0, bus.empty}, 64'd1);

    // 6. asynchronous reset mid-operation
    store(64'h400, 64'h4);
    store(64'h408, 64'h5);
    store(64'h410, 64'h6);
    check("ar_count", 64'(bus.count), 64'd3);
    #2;
    reset = 1'b0;
    #1;
    check("ar_req",   {63'd0, bus.mem_wr_req}, 64'd0);
    check("ar_empty", {63'd0, bus.empty}, 64'd1);
    check("ar_cnt0",  64'(bus.count), 64'd0);
    reset = 1'b1;
    tick();
    load_expect("ar_load", 64'h408, 64'h9999, 64'h9999);
    store(64'h500, 64'h7);
    check("ar_after", 64'(bus.count), 64'd1);
    pop_expect("ar_pop", 64'h500, 64'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Write-back store buffer between the pipelined datapath's memory-stage data-memory port and a slower backing data memory with a request/acknowledge write interface. Stores from the datapath are absorbed into a small FIFO in one cycle and drained to the backing memory in order. Loads read the backing memory combinationally, with store-to-load forwarding from the youngest matching buffered entry. When the FIFO is full and a new store arrives, the block raises `stall` back to the pipeline.

## Interface

Parameters:
- `N`, 64: address and data width.
- `DEPTH`, 4: number of buffer entries; must be a power of two, at least 2.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low. Reset is asserted while `reset`=0.
- `DM_addr`, in, N: load/store address from the memory stage.
- `DM_writeData`, in, N: store data.
- `DM_writeEnable`, in, 1: store request this cycle.
- `DM_readEnable`, in, 1: load request this cycle.
- `DM_readData`, out, N: load result (combinational).
- `stall`, out, 1: store not accepted this cycle; the pipeline must hold.
- `mem_wr_req`, out, 1: head entry is valid and presented to the backing memory.
- `mem_wr_addr`, out, N: head entry address.
- `mem_wr_data`, out, N: head entry data.
- `mem_wr_ack`, in, 1: backing memory accepts the head entry at this edge.
- `mem_rd_addr`, out, N: backing-memory read address; always equals `DM_addr`.
- `mem_rd_data`, in, N: backing-memory read data (combinational).
- `count`, out, $clog2(DEPTH)+1: number of occupied entries.
- `empty`, out, 1: `count`==0.

## Operation

**Storage and pointers**
- Circular FIFO of {addr, data} entries.
- Head and tail pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- `count` is maintained separately; full means `count`==DEPTH.

**Push**
- Occurs at a rising edge when `DM_writeEnable`=1 and the FIFO is not full.
- Writes {`DM_addr`, `DM_writeData`} at the tail; the tail advances.

**Stall**
- `stall` = `DM_writeEnable` & full, computed combinationally.
- It does not depend on `mem_wr_ack`. A store arriving while full is refused even if a pop happens at the same edge.
- The pipeline re-presents the store in the next cycle.

**Pop**
- Occurs at a rising edge when `mem_wr_req`=1 and `mem_wr_ack`=1. The head advances.
- `mem_wr_ack` while `mem_wr_req`=0 is ignored.

**Count update**
- Push and pop at the same edge (only possible when not full): `count` is unchanged and both pointers advance.
- Push only: +1. Pop only: −1. Never exceeds DEPTH and never underflows.

**Drain interface**
- `mem_wr_req` = ~`empty`.
- `mem_wr_addr` and `mem_wr_data` are driven from the head entry. They stay stable while `mem_wr_req`=1 and no ack has been taken.
- Drain order equals push order.

**Load forwarding**
- `DM_readData` is selected as follows:
  - If any valid entry has addr == `DM_addr` (full N-bit compare): the data of the youngest such entry, i.e. the one closest to the tail.
  - Otherwise: `mem_rd_data`.
- The search covers occupied entries only, including the head currently being drained.
- A store presented in the same cycle is not forwarded.
- `DM_readEnable` only qualifies use by the pipeline. `DM_readData` is valid whenever it is asserted, and its value otherwise is don't-care.

**Simultaneous store and load**
- Not generated by the datapath.
- If it does occur, the push proceeds normally and `DM_readData` follows the forwarding rule above.

## Timing

**Reset values**
- While `reset`=0: `count`=0, `empty`=1, `mem_wr_req`=0, `stall`=`DM_writeEnable` & 0 = 0, both pointers 0.
- Entry contents are don't-care.
- Reset mid-drain discards all entries immediately (asynchronously). `mem_wr_req` drops in the same cycle.

**Latencies**
- Store to backing memory: a store pushed at edge k into an empty buffer gives `mem_wr_req`=1 with that entry during cycle k+1. The earliest pop is at edge k+1.
- Store to load: a store pushed at edge k is forwardable to a load in cycle k+1 and after, until it is popped.
- `stall`, `DM_readData` and `mem_rd_addr` are combinational: zero cycles.
- `count` and `empty` update one edge after the push/pop event.

**Throughput**
- One push and one pop per cycle. With `mem_wr_ack` held at 1, back-to-back stores never stall.

## Test plan

1. **Reset behaviour.** Hold `reset`=0 and assert `DM_writeEnable`=1 → no push, `count`=0, `mem_wr_req`=0. Release reset → the first store is accepted.
2. **In-order drain.** With `mem_wr_ack`=0, store A=0x10/D=0x11, then 0x18/0x22, then 0x20/0x33 → `count`=3, `mem_wr_addr`=0x10. Pulse ack three times → outputs 0x10/0x11, 0x18/0x22, 0x20/0x33 in that order, then `empty`=1.
3. **Full and stall.** With DEPTH=4 and ack=0, push 4 stores, then present a fifth (0x40/0x55) → `stall`=1 and `count` stays 4. Ack for one edge while the fifth is still presented → it is still refused. Next cycle → `stall`=0 and it is pushed; `count`=4. Check the tail wrap by draining all entries in order.
4. **Forwarding.** Store 0x100/0xAAAA, then 0x100/0xBBBB, with ack=0. Load 0x100 with `mem_rd_data`=0x1234 → `DM_readData`=0xBBBB. Load 0x108 → 0x1234. After both pops, load 0x100 → 0x1234.
5. **Simultaneous push/pop.** With `count`=2, `mem_wr_req`=1, ack=1 and a new store at the same edge → `count` remains 2, the head advances, and the new entry sits at the tail.
6. **Reset mid-operation.** With `count`=3, assert `reset`=0 between edges → `mem_wr_req`=0 and `empty`=1 immediately. After release, a load of a previously buffered address returns `mem_rd_data`.
